mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_if.sv | 33 +++
 rtl/mul_sequencer.sv | 103 ++++++++++
 tb/tb_mul_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The master drives the request; the slave returns status and the product.
interface mul_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R1;
  logic             Overflow;

  modport master (
    output start,
    output X,
    output Y,
    input  busy,
    input  done,
    input  R1,
    input  Overflow
  );

  modport slave (
    input  start,
    input  X,
    input  Y,
    output busy,
    output done,
    output R1,
    output Overflow
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-and-add unsigned multiplier.
// Processes one multiplier bit per cycle into a double-width accumulator.
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] w_acc_add;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_r1;
  logic [CW-1:0]      r_cnt;
  logic               r_ovf;
  logic               w_accept;
  logic               w_last;
  logic               w_run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    w_run    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_run  = 1'b1;
        w_last = (r_cnt == LAST);
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Multiplicand shifts left, multiplier right: bit i meets X << i.
  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_r1     <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, bus.X};
      r_mplier <= bus.Y;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_acc    <= w_acc_add;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_r1  <= w_acc_add[WIDTH-1:0];
        r_ovf <= |w_acc_add[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.R1       = r_r1;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer at WIDTH=16 and WIDTH=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16_n;
  logic rst3_n;

  mul_sequencer_if #(.WIDTH(16)) b16 ();
  mul_sequencer_if #(.WIDTH(3))  b3 ();

  mul_sequencer #(.WIDTH(16)) u16 (
    .clk   (clk),
    .rst_n (rst16_n),
    .bus   (b16.slave)
  );

  mul_sequencer #(.WIDTH(3)) u3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (b3.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int    w;
    int    x;
    int    y;
    int    r1;
    int    ovf;
    string name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s,
                       input int x, input int y);
    if (w == 16) begin
      b16.start = s;
      b16.X     = x[15:0];
      b16.Y     = y[15:0];
    end else begin
      b3.start = s;
      b3.X     = x[2:0];
      b3.Y     = y[2:0];
    end
  endtask

  task automatic set_start(input int w, input logic s);
    if (w == 16) b16.start = s;
    else b3.start = s;
  endtask

  task automatic sample(input int w, output logic bz,
                        output logic dn, output logic [31:0] r1,
                        output logic [31:0] ov);
    if (w == 16) begin
      bz = b16.busy;
      dn = b16.done;
      r1 = {16'd0, b16.R1};
      ov = {31'd0, b16.Overflow};
    end else begin
      bz = b3.busy;
      dn = b3.done;
      r1 = {29'd0, b3.R1};
      ov = {31'd0, b3.Overflow};
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    int          bcnt;
    logic        seen;
    logic        moved;
    logic        bz;
    logic        dn;
    logic [31:0] r1;
    logic [31:0] ov;
    logic [31:0] r1_0;
    logic [31:0] ov_d;
    n     = 0;
    bcnt  = 0;
    seen  = 1'b0;
    moved = 1'b0;
    @(negedge clk);
    sample(v.w, bz, dn, r1_0, ov);
    drive(v.w, 1'b1, v.x, v.y);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      set_start(v.w, 1'b0);
      drive(v.w, 1'b0, 0, 0);
      n++;
      sample(v.w, bz, dn, r1, ov);
      if (bz) bcnt++;
      if (!dn && r1 != r1_0) moved = 1'b1;
      if (dn) begin
        seen = 1'b1;
        ov_d = ov;
        check({v.name, " r1"}, r1, v.r1);
        check({v.name, " ovf"}, ov, v.ovf);
      end
    end
    check({v.name, " done_seen"}, {31'd0, seen}, 1);
    check({v.name, " latency"}, n, v.w + 1);
    check({v.name, " busy_cycles"}, bcnt, v.w);
    check({v.name, " r1_stable_run"}, {31'd0, moved}, 0);
    repeat (2) @(negedge clk);
    sample(v.w, bz, dn, r1, ov);
    check({v.name, " done_single"}, {31'd0, dn}, 0);
    check({v.name, " idle_busy"}, {31'd0, bz}, 0);
    check({v.name, " r1_hold"}, r1, v.r1);
    check({v.name, " ovf_hold"}, ov, v.ovf);
  endtask

  initial begin
    logic        bz;
    logic        dn;
    logic [31:0] r1;
    logic [31:0] ov;
    int          dcnt;
    int          bcnt;
    int          dpos;
    int          prev;
    logic        seen;

    vecs[0] = '{3, 2, 3, 6, 0, "w3_2x3"};
    vecs[1] = '{3, 3, 4, 4, 1, "w3_3x4"};
    vecs[2] = '{3, 7, 7, 1, 1, "w3_7x7"};
    vecs[3] = '{3, 3, 7, 5, 1, "w3_3x7"};
    vecs[4] = '{16, 255, 257, 65535, 0, "w16_255x257"};
    vecs[5] = '{16, 256, 256, 0, 1, "w16_256x256"};
    vecs[6] = '{16, 0, 65535, 0, 0, "w16_0xffff"};
    vecs[7] = '{16, 1234, 5, 6170, 0, "w16_1234x5"};
    vecs[8] = '{16, 65535, 65535, 1, 1, "w16_max"};

    rst16_n = 1'b0;
    rst3_n  = 1'b0;
    drive(16, 1'b0, 0, 0);
    drive(3, 1'b0, 0, 0);
    repeat (2) @(negedge clk);

    sample(16, bz, dn, r1, ov);
    check("rst16 busy", {31'd0, bz}, 0);
    check("rst16 done", {31'd0, dn}, 0);
    check("rst16 r1", r1, 0);
    check("rst16 ovf", ov, 0);
    sample(3, bz, dn, r1, ov);
    check("rst3 busy", {31'd0, bz}, 0);
    check("rst3 done", {31'd0, dn}, 0);
    check("rst3 r1", r1, 0);
    check("rst3 ovf", ov, 0);
    rst16_n = 1'b1;
    rst3_n  = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Start pulsed mid-run with new operands must be ignored.
    dcnt = 0;
    dpos = 0;
    r1   = 0;
    ov   = 0;
    @(negedge clk);
    drive(16, 1'b1, 5, 6);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) set_start(16, 1'b0);
      if (n == 3) drive(16, 1'b1, 9, 9);
      if (n == 4) drive(16, 1'b0, 100, 77);
      if (b16.done) begin
        dcnt++;
        dpos = n;
        r1   = {16'd0, b16.R1};
        ov   = {31'd0, b16.Overflow};
      end
    end
    check("ignore r1", r1, 30);
    check("ignore ovf", ov, 0);
    check("ignore done_count", dcnt, 1);
    check("ignore done_pos", dpos, 17);

    // Reset on the 5th RUN cycle, with start high at the reset edge.
    @(negedge clk);
    drive(16, 1'b1, 100, 100);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) set_start(16, 1'b0);
    end
    check("abort busy_before", {31'd0, b16.busy}, 1);
    rst16_n = 1'b0;
    set_start(16, 1'b1);
    @(negedge clk);
    sample(16, bz, dn, r1, ov);
    check("abort busy", {31'd0, bz}, 0);
    check("abort done", {31'd0, dn}, 0);
    check("abort r1", r1, 0);
    check("abort ovf", ov, 0);
    rst16_n = 1'b1;
    set_start(16, 1'b0);
    dcnt = 0;
    bcnt = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (b16.done) dcnt++;
      if (b16.busy) bcnt++;
    end
    check("abort no_done", dcnt, 0);
    check("abort no_busy", bcnt, 0);

    // First edge after release with start high is accepted.
    rst16_n = 1'b0;
    @(negedge clk);
    rst16_n = 1'b1;
    drive(16, 1'b1, 3, 3);
    @(negedge clk);
    check("release busy", {31'd0, b16.busy}, 1);
    set_start(16, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (b16.done) begin
        seen = 1'b1;
        check("release r1", {16'd0, b16.R1}, 9);
      end
    end
    check("release done_seen", {31'd0, seen}, 1);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    dcnt = 0;
    prev = -1;
    @(negedge clk);
    drive(3, 1'b1, 2, 2);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (b3.done) begin
        dcnt++;
        check("b2b r1", {29'd0, b3.R1}, 4);
        check("b2b ovf", {31'd0, b3.Overflow}, 0);
        if (prev >= 0) check("b2b period", n - prev, 5);
        else check("b2b first", n, 4);
        prev = n;
      end
    end
    set_start(3, 1'b0);
    check("b2b pulses", dcnt, 6);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
